// File: rtl/baudrate_generator_pkg.sv
// -----------------------------------------------------------------------------
// baudrate_generator_pkg
// Shared UART constants used by the sender, the receiver and the baud-rate
// generator, plus the operating-mode encoding of the phase accumulator.
// -----------------------------------------------------------------------------
package baudrate_generator_pkg;

  localparam int unsigned DEFAULT_BAUD_RATE = 32'd115_200;
  localparam int unsigned DEFAULT_CLK_FREQ  = 32'd50_000_000;
  localparam int          FREQ_W            = 32;

  // What the accumulator does on the next clock edge (reset is handled apart).
  typedef enum logic [1:0] {
    MODE_RESTART = 2'd0,  // clk_freq changed: restart counting from zero
    MODE_IDLE    = 2'd1,  // clk_freq == 0: no clock information, no ticks
    MODE_SAT     = 2'd2,  // clk_freq <= BAUD_RATE: tick on every cycle
    MODE_RUN     = 2'd3   // normal fractional accumulation
  } nco_mode_e;

endpackage : baudrate_generator_pkg

// File: rtl/baudrate_generator.sv
// -----------------------------------------------------------------------------
// baudrate_generator
// Fractional phase-accumulator (NCO) tick generator. Each cycle the
// accumulator gains BAUD_RATE; when it reaches clk_freq it wraps by
// subtracting clk_freq and a one-cycle baud_tick is issued, so the long-run
// tick rate is exactly BAUD_RATE for the supplied clock frequency.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   clk_freq   in   system clock frequency in Hz (FREQ_W bits)
//   baud_tick  out  registered one-cycle pulse, one per bit period
// -----------------------------------------------------------------------------
module baudrate_generator #(
  parameter int unsigned BAUD_RATE = baudrate_generator_pkg::DEFAULT_BAUD_RATE,
  parameter int          FREQ_W    = baudrate_generator_pkg::FREQ_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] clk_freq,
  output logic              baud_tick
);

  import baudrate_generator_pkg::*;

  // Increment widened to the accumulator width; one guard bit above FREQ_W
  // means acc + BAUD_RATE can never wrap since acc < clk_freq < 2^FREQ_W.
  localparam logic [FREQ_W:0] BAUD_EXT = (FREQ_W+1)'(BAUD_RATE);

  logic [FREQ_W:0]   acc_r;
  logic [FREQ_W-1:0] freq_r;
  logic              baud_tick_r;

  logic [FREQ_W:0]   freq_ext_s;
  logic [FREQ_W:0]   sum_s;
  logic [FREQ_W:0]   acc_next_s;
  logic              tick_next_s;
  nco_mode_e         mode_s;

  assign freq_ext_s = {1'b0, clk_freq};
  assign sum_s      = acc_r + BAUD_EXT;

  // Classify the current cycle; a frequency change dominates the other cases.
  always_comb begin
    mode_s = MODE_RUN;
    if (clk_freq != freq_r) begin
      mode_s = MODE_RESTART;
    end else if (clk_freq == {FREQ_W{1'b0}}) begin
      mode_s = MODE_IDLE;
    end else if (freq_ext_s <= BAUD_EXT) begin
      mode_s = MODE_SAT;
    end else begin
      mode_s = MODE_RUN;
    end
  end

  // Next accumulator value and tick decision for each mode.
  always_comb begin
    acc_next_s  = {(FREQ_W+1){1'b0}};
    tick_next_s = 1'b0;
    case (mode_s)
      MODE_RESTART: begin
        acc_next_s  = {(FREQ_W+1){1'b0}};
        tick_next_s = 1'b0;
      end
      MODE_IDLE: begin
        acc_next_s  = {(FREQ_W+1){1'b0}};
        tick_next_s = 1'b0;
      end
      MODE_SAT: begin
        acc_next_s  = {(FREQ_W+1){1'b0}};
        tick_next_s = 1'b1;
      end
      MODE_RUN: begin
        if (sum_s >= freq_ext_s) begin
          acc_next_s  = sum_s - freq_ext_s;
          tick_next_s = 1'b1;
        end else begin
          acc_next_s  = sum_s;
          tick_next_s = 1'b0;
        end
      end
      default: begin
        acc_next_s  = {(FREQ_W+1){1'b0}};
        tick_next_s = 1'b0;
      end
    endcase
  end

  // State registers; freq_r always follows clk_freq so a change is seen once.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {(FREQ_W+1){1'b0}};
      baud_tick_r <= 1'b0;
      freq_r      <= clk_freq;
    end else begin
      acc_r       <= acc_next_s;
      baud_tick_r <= tick_next_s;
      freq_r      <= clk_freq;
    end
  end

  assign baud_tick = baud_tick_r;

endmodule : baudrate_generator

// File: tb/tb_baudrate_generator.sv
// -----------------------------------------------------------------------------
// tb_baudrate_generator
// Directed, self-checking bench for baudrate_generator. Tick edges are
// numbered from the last edge at which rst (or a frequency change) was
// sampled; expected tick edges are ceil(m*F/B) computed by the bench.
// -----------------------------------------------------------------------------
module tb_baudrate_generator;

  localparam int unsigned B = 32'd115_200;

  logic        clk;
  logic        rst;
  logic [31:0] clk_freq;
  logic        baud_tick;

  int checks;
  int errors;
  int edge_n;

  baudrate_generator #(
    .BAUD_RATE (B),
    .FREQ_W    (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_freq  (clk_freq),
    .baud_tick (baud_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n = edge_n + 1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply reset for n edges with the given frequency, then release.
  task automatic do_reset(input logic [31:0] f, input int n);
    clk_freq = f;
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      check("tick_in_reset", {63'd0, baud_tick}, 64'd0);
    end
    rst = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    logic [63:0] exp_edge;
    int          m;
    int          last_edge;
    int          first_edge;
    int          second_edge;
    int          ones;
    int          e_chg;
    logic        prev;
    logic        iv_ok;
    logic        found;

    checks = 0;
    errors = 0;
    edge_n = 0;
    rst = 1'b1;
    clk_freq = 32'd50_000_000;

    // 50 MHz: first 100 ticks land on ceil(m*F/B), intervals 434/435.
    do_reset(32'd50_000_000, 5);
    m = 1; last_edge = 0; prev = 1'b0; first_edge = 0; second_edge = 0;
    while (m <= 100 && edge_n < 50_000) begin
      step();
      if (baud_tick) begin
        exp_edge = (64'(m) * 64'd50_000_000 + 64'(B) - 64'd1) / 64'(B);
        check("tick_edge", 64'(edge_n), exp_edge);
        check("no_adjacent", {63'd0, prev}, 64'd0);
        if (m == 1) first_edge = edge_n;
        if (m == 2) second_edge = edge_n;
        if (m > 1) begin
          iv_ok = ((edge_n - last_edge) == 434) || ((edge_n - last_edge) == 435);
          check("interval", {63'd0, iv_ok}, 64'd1);
        end
        last_edge = edge_n;
        m = m + 1;
      end
      prev = baud_tick;
    end
    check("tick_count", 64'(m - 1), 64'd100);
    check("first_tick", 64'(first_edge), 64'd435);
    check("second_tick", 64'(second_edge), 64'd869);
    check("hundredth_tick", 64'(last_edge), 64'd43403);

    // Exact multiple: tick every 16 cycles, no jitter.
    do_reset(32'd1_843_200, 2);
    for (int e = 1; e <= 80; e++) begin
      step();
      check("div16", {63'd0, baud_tick}, {63'd0, (e % 16) == 0});
    end

    // Mid-run frequency change restarts counting at the change edge.
    do_reset(32'd50_000_000, 2);
    for (int i = 0; i < 1000; i++) step();
    clk_freq = 32'd1_843_200;
    step();
    e_chg = edge_n;
    check("tick_at_change", {63'd0, baud_tick}, 64'd0);
    for (int k = 1; k <= 48; k++) begin
      step();
      check("after_change", {63'd0, baud_tick}, {63'd0, (k % 16) == 0});
    end
    check("change_edge", 64'(e_chg), 64'd1001);

    // clk_freq == 0: no tick at all.
    clk_freq = 32'd0;
    step();
    check("tick_zero_change", {63'd0, baud_tick}, 64'd0);
    ones = 0;
    for (int i = 0; i < 10_000; i++) begin
      step();
      if (baud_tick) ones = ones + 1;
    end
    check("zero_freq_ticks", 64'(ones), 64'd0);

    // clk_freq below BAUD_RATE: saturated, tick every cycle.
    clk_freq = 32'd100_000;
    step();
    check("tick_sat_change", {63'd0, baud_tick}, 64'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("saturated", {63'd0, baud_tick}, 64'd1);
    end

    // One-cycle reset at edge 300 of a 50 MHz run; next tick at 300+435.
    do_reset(32'd50_000_000, 2);
    for (int i = 0; i < 299; i++) step();
    rst = 1'b1;
    step();
    check("reset_edge", 64'(edge_n), 64'd300);
    check("tick_after_rst", {63'd0, baud_tick}, 64'd0);
    rst = 1'b0;
    found = 1'b0;
    while (!found && edge_n < 2000) begin
      step();
      if (baud_tick) found = 1'b1;
    end
    check("tick_found", {63'd0, found}, 64'd1);
    check("tick_after_rst_edge", 64'(edge_n), 64'd735);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_baudrate_generator
